digit_editor_scan: RTL and testbench
====================================

DIGIT_EDITOR_SCAN -- requirements
Module: digit_editor_scan

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of BCD digits, legal range 2..8.
REQ-002 Parameter SCAN_DIV, default 1000: clock cycles each digit stays selected during scanning, minimum 2.
REQ-003 Parameter BLINK_DIV, default 250000: clock cycles per cursor-blink half-period, minimum 2.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 Rst  input  1  asynchronous, active-high reset.
REQ-006 inc  input  1  debounced increment button, active-low (0 = pressed).
REQ-007 dec  input  1  debounced decrement button, active-low.
REQ-008 nxt  input  1  debounced cursor-advance button, active-low.
REQ-009 carry_en  input  1  1 = increment/decrement ripples carry/borrow into higher digits; 0 = digits are independent.
REQ-010 clr  input  1  synchronous, active-high: zero all digits.
REQ-011 value  output  4*NUM_DIGITS  registered BCD digits; digit 0 in bits [3:0].
REQ-012 cursor  output  3  index of the digit under edit, 0..NUM_DIGITS-1.
REQ-013 seg_dat  output  8  active-high segments {dp,g,f,e,d,c,b,a} for the currently scanned digit.
REQ-014 seg_sel  output  NUM_DIGITS  active-low one-hot select of the currently scanned digit.

Function
REQ-015 A press event is a falling edge: the sampled input is 0 and its one-cycle-delayed copy is 1; each copy SHALL reset to 1 so that no event fires out of reset.
REQ-016 An event SHALL take effect on the same rising edge that loads the delayed copy with 0, i.e. one cycle after the input is first sampled low.
REQ-017 inc event: the cursor digit goes +1, with 9 wrapping to 0; if carry_en=1 and the digit wraps, +1 ripples into the next higher digit, repeating while wraps continue.
REQ-018 A carry out of digit NUM_DIGITS-1 SHALL be discarded (e.g. 9999 -> 0000); digits below the cursor are never modified.
REQ-019 dec event: the cursor digit goes -1, with 0 wrapping to 9; with carry_en=1 the borrow ripples upward symmetrically, and a borrow out of the top digit is discarded (0000 -> 9999 when cursor=0).
REQ-020 Simultaneous inc and dec events SHALL cancel: no digit change.
REQ-021 nxt event: cursor+1, with NUM_DIGITS-1 wrapping to 0.
REQ-022 nxt together with inc or dec: the digit operation uses the old cursor, and the cursor advances on the same edge.
REQ-023 clr=1 SHALL force all digits to 0 on that edge and override inc/dec; the cursor is unaffected.
REQ-024 Scan: a cycle counter runs 0..SCAN_DIV-1; at terminal count, the scan index advances and wraps NUM_DIGITS-1 -> 0.
REQ-025 seg_sel is the low-active one-hot of the scan index.
REQ-026 Blink: a counter runs 0..BLINK_DIV-1 and toggles the blink phase at terminal count; the phase resets to 1 (visible).
REQ-027 seg_dat SHALL be the 7-segment decode of the scanned digit, with dp=1 when scan index == cursor.
REQ-028 When scan index == cursor and blink phase = 0, seg_dat SHALL be 8'h80 (digit blanked, dp lit).
REQ-029 seg_dat and seg_sel SHALL be registered, changing only on clock edges; codes 10-15 cannot occur and decode to blank.

Reset
REQ-030 On Rst, asynchronously: all digits 0, cursor 0, scan index 0, scan and blink counters 0, blink phase 1, edge-detect copies 1.
REQ-031 On Rst: seg_sel = all ones except bit0 = 0; seg_dat = 8'hBF (digit 0 showing "0" with dp).
REQ-032 Reset asserted mid-ripple or mid-scan SHALL abandon the operation with no partial state kept.

Structure
REQ-033 The shared package SHALL hold the segment code constants for 0-9 and blank, and the BCD digit type.
REQ-034 The 7-segment decode SHALL be the existing bcd_to_7seg sub-module, with one instance on the scan multiplexer output.
REQ-035 The carry ripple SHALL be combinational within one cycle, with no multi-cycle state.

Verification (NUM_DIGITS=4, SCAN_DIV=4, BLINK_DIV=16)
REQ-036 Reset release with all buttons high -> value=0000, cursor=0, no digit change for 100 cycles.
REQ-037 carry_en=1, value=0999, cursor=0, single inc press -> value=1000 exactly one cycle after inc is sampled low.
REQ-038 carry_en=0, value=0009, inc press -> 0000; dec press -> 0009; value=0000, carry_en=1, dec press -> 9999.
REQ-039 nxt pressed 5 times -> cursor sequence 1,2,3,0,1; inc+nxt on the same cycle with cursor=1 -> digit1 increments and cursor=2.
REQ-040 inc and dec on the same cycle -> value unchanged; clr asserted together with inc -> value=0000.
REQ-041 Free-run 64 cycles -> seg_sel steps 1110,1101,1011,0111 every 4 cycles; the cursor digit shows 8'h80 during phase-0 windows of 16 cycles.

Source files
------------

// File: rtl/digit_editor_scan_pkg.sv
// Shared types and constants for the digit editor / display scanner.
//   bcd_t      : one BCD digit
//   SEG_*      : active-high segment codes {dp,g,f,e,d,c,b,a}
package digit_editor_scan_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;
  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_DP    = 8'h80;

endpackage

// File: rtl/digit_editor_scan_if.sv
// Button/display bundle for digit_editor_scan.
//   inc/dec/nxt : debounced buttons, active-low
//   carry_en    : ripple carry/borrow into higher digits
//   clr         : synchronous clear of all digits
//   value       : BCD digits, digit 0 in [3:0]
//   cursor      : digit under edit
//   seg_dat     : segments {dp,g,f,e,d,c,b,a} of the scanned digit
//   seg_sel     : active-low one-hot digit select
interface digit_editor_scan_if #(parameter int NUM_DIGITS = 4);
  logic                    inc;
  logic                    dec;
  logic                    nxt;
  logic                    carry_en;
  logic                    clr;
  logic [4*NUM_DIGITS-1:0] value;
  logic [2:0]              cursor;
  logic [7:0]              seg_dat;
  logic [NUM_DIGITS-1:0]   seg_sel;

  modport master (
    output inc, dec, nxt, carry_en, clr,
    input  value, cursor, seg_dat, seg_sel
  );

  modport slave (
    input  inc, dec, nxt, carry_en, clr,
    output value, cursor, seg_dat, seg_sel
  );
endinterface

// File: rtl/digit_editor_scan_bcd_to_7seg.sv
// bcd_to_7seg: combinational BCD to 7-segment decode, dp always 0.
//   bcd : digit in
//   seg : {dp,g,f,e,d,c,b,a}; codes 10-15 decode to blank
module bcd_to_7seg
  import digit_editor_scan_pkg::*;
(
  input  bcd_t       bcd,
  output logic [7:0] seg
);
  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/digit_editor_scan.sv
// digit_editor_scan: multi-digit BCD editor driven by three buttons, with a
// multiplexed 7-segment scanner and a blinking cursor digit.
//   clk : clock
//   Rst : asynchronous active-high reset
//   bus : digit_editor_scan_if.slave (buttons in, digits/cursor/segments out)
module digit_editor_scan
  import digit_editor_scan_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int BLINK_DIV  = 250000
) (
  input  logic                 clk,
  input  logic                 Rst,
  digit_editor_scan_if.slave   bus
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);

  // {nxt,dec,inc}: sampled copy and one-cycle-delayed copy
  logic [2:0] btn_s, btn_d, ev;
  logic       do_inc, do_dec;

  bcd_t [NUM_DIGITS-1:0] digits, digits_nxt;
  logic [IW-1:0]         cur_q;

  logic [SW-1:0] scan_cnt;
  logic [IW-1:0] scan_idx;
  logic [BW-1:0] blink_cnt;
  logic          blink_ph;
  logic [7:0]    seg_raw, seg_dat_q;
  logic [NUM_DIGITS-1:0] seg_sel_q;

  // falling edge: delayed copy still high, sampled copy already low
  assign ev     = btn_d & ~btn_s;
  assign do_inc = ev[0] & ~ev[1];
  assign do_dec = ev[1] & ~ev[0];

  // Single-cycle ripple: 'active' starts at the cursor digit and keeps
  // propagating upward only while a digit wraps and carry is enabled.
  // Anything falling off the top digit is simply dropped.
  always_comb begin
    logic active;
    digits_nxt = digits;
    active     = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i == int'(cur_q)) active = do_inc | do_dec;
      if (active) begin
        if (do_inc) begin
          if (digits[i] == BCD_MAX) begin
            digits_nxt[i] = 4'd0;
            active        = bus.carry_en;
          end else begin
            digits_nxt[i] = digits[i] + 4'd1;
            active        = 1'b0;
          end
        end else begin
          if (digits[i] == 4'd0) begin
            digits_nxt[i] = BCD_MAX;
            active        = bus.carry_en;
          end else begin
            digits_nxt[i] = digits[i] - 4'd1;
            active        = 1'b0;
          end
        end
      end
    end
    if (bus.clr) digits_nxt = '0;
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      btn_s  <= '1;
      btn_d  <= '1;
      digits <= '0;
      cur_q  <= '0;
    end else begin
      btn_s  <= {bus.nxt, bus.dec, bus.inc};
      btn_d  <= btn_s;
      digits <= digits_nxt;
      if (ev[2]) cur_q <= (cur_q == LAST) ? '0 : cur_q + IW'(1);
    end
  end

  bcd_to_7seg u_dec (
    .bcd (digits[scan_idx]),
    .seg (seg_raw)
  );

  // Segment outputs are registered from the current scan state, so they
  // trail scan_idx by one cycle; the reset values match scan index 0.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      scan_cnt  <= '0;
      scan_idx  <= '0;
      blink_cnt <= '0;
      blink_ph  <= 1'b1;
      seg_sel_q <= ~NUM_DIGITS'(1);
      seg_dat_q <= SEG_0 | SEG_DP;
    end else begin
      if (scan_cnt == SW'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        scan_idx <= (scan_idx == LAST) ? '0 : scan_idx + IW'(1);
      end else begin
        scan_cnt <= scan_cnt + SW'(1);
      end
      if (blink_cnt == BW'(BLINK_DIV - 1)) begin
        blink_cnt <= '0;
        blink_ph  <= ~blink_ph;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
      seg_sel_q <= ~(NUM_DIGITS'(1) << scan_idx);
      if (scan_idx == cur_q)
        seg_dat_q <= blink_ph ? (seg_raw | SEG_DP) : SEG_DP;
      else
        seg_dat_q <= seg_raw;
    end
  end

  assign bus.value   = digits;
  assign bus.cursor  = 3'(cur_q);
  assign bus.seg_dat = seg_dat_q;
  assign bus.seg_sel = seg_sel_q;

endmodule

// File: tb/tb_digit_editor_scan.sv
module tb_digit_editor_scan;

  typedef struct {
    int          cyc;
    int          kind;   // 0: value/cursor, 1: seg_sel/seg_dat
    logic [15:0] val;
    logic [2:0]  cur;
    logic [3:0]  ss;
    logic [7:0]  sd;
    string       nm;
  } exp_t;

  logic clk = 1'b0;
  logic Rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t e;

  logic [15:0] exp_val = 16'h0000;
  logic [2:0]  exp_cur = 3'd0;

  digit_editor_scan_if #(.NUM_DIGITS(4)) bus ();

  digit_editor_scan #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(16)) dut (
    .clk (clk),
    .Rst (Rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_vc(input int c, input logic [15:0] v, input logic [2:0] cu, input string nm);
    exp_t x;
    x.cyc = c; x.kind = 0; x.val = v; x.cur = cu; x.ss = '0; x.sd = '0; x.nm = nm;
    sb.push_back(x);
  endtask

  task automatic push_seg(input int c, input logic [3:0] ss, input logic [7:0] sd, input string nm);
    exp_t x;
    x.cyc = c; x.kind = 1; x.val = '0; x.cur = '0; x.ss = ss; x.sd = sd; x.nm = nm;
    sb.push_back(x);
  endtask

  // One button press: low for one cycle. The change must appear exactly
  // two edges after the drive point (one edge after the low is sampled).
  // clr, when requested, is high on the edge where the event takes effect.
  task automatic press(input logic pi, input logic pd, input logic pn, input logic pc,
                       input logic [15:0] ev, input logic [2:0] ec, input string nm);
    push_vc(cyc + 1, exp_val, exp_cur, {nm, "_hold"});
    push_vc(cyc + 2, ev, ec, nm);
    bus.inc = ~pi; bus.dec = ~pd; bus.nxt = ~pn;
    tick();
    bus.inc = 1'b1; bus.dec = 1'b1; bus.nxt = 1'b1; bus.clr = pc;
    tick();
    bus.clr = 1'b0;
    tick();
    exp_val = ev;
    exp_cur = ec;
  endtask

  // Monitor: compares whatever expectations fall due on this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.cyc != cyc) begin
        errors++;
        $display("FAIL %s: missed check at cycle %0d, now %0d", e.nm, e.cyc, cyc);
      end else if (e.kind == 0) begin
        if (bus.value !== e.val || bus.cursor !== e.cur) begin
          errors++;
          $display("FAIL %s @%0d: value=%h cursor=%0d, want value=%h cursor=%0d",
                   e.nm, cyc, bus.value, bus.cursor, e.val, e.cur);
        end
      end else begin
        if (bus.seg_sel !== e.ss || bus.seg_dat !== e.sd) begin
          errors++;
          $display("FAIL %s @%0d: seg_sel=%b seg_dat=%h, want seg_sel=%b seg_dat=%h",
                   e.nm, cyc, bus.seg_sel, bus.seg_dat, e.ss, e.sd);
        end
      end
    end
  end

  initial begin
    int r;
    bus.inc = 1'b1; bus.dec = 1'b1; bus.nxt = 1'b1;
    bus.carry_en = 1'b0; bus.clr = 1'b0;
    Rst = 1'b1;

    // reset state
    tick();
    push_vc(cyc + 1, 16'h0000, 3'd0, "reset_val");
    push_seg(cyc + 1, 4'b1110, 8'hBF, "reset_seg");
    tick();
    tick();
    Rst = 1'b0;
    r = cyc;

    // Free run. After edge r+n the outputs reflect scan state after edge
    // r+n-1: index m/4 mod 4 and blink phase 1 for m/16 even (m = n-1).
    // Cursor digit is 0 with value 0: "0"+dp = BF, blanked = 80, others 3F.
    for (int n = 1; n <= 100; n++) begin
      if (n <= 64) begin
        int m, idx;
        logic [3:0] ss;
        logic [7:0] sd;
        m   = n - 1;
        idx = (m / 4) % 4;
        ss  = ~(4'b0001 << idx);
        if (idx != 0)              sd = 8'h3F;
        else if ((m / 16) % 2 == 0) sd = 8'hBF;
        else                       sd = 8'h80;
        push_seg(r + n, ss, sd, "scan");
      end
      if (n % 10 == 0) push_vc(r + n, 16'h0000, 3'd0, "idle");
    end
    repeat (100) tick();

    // independent digits
    press(0, 1, 0, 0, 16'h0009, 3'd0, "dec_wrap_nc");
    press(1, 0, 0, 0, 16'h0000, 3'd0, "inc_wrap_nc");
    press(0, 1, 0, 0, 16'h0009, 3'd0, "dec_wrap_nc2");
    press(0, 0, 1, 0, 16'h0009, 3'd1, "nxt_a");
    press(0, 1, 0, 0, 16'h0099, 3'd1, "dec_d1");
    press(0, 0, 1, 0, 16'h0099, 3'd2, "nxt_b");
    press(0, 1, 0, 0, 16'h0999, 3'd2, "dec_d2");
    press(0, 0, 1, 0, 16'h0999, 3'd3, "nxt_c");
    press(0, 0, 1, 0, 16'h0999, 3'd0, "nxt_wrap");

    // ripple carry / borrow
    bus.carry_en = 1'b1;
    press(1, 0, 0, 0, 16'h1000, 3'd0, "inc_ripple");
    press(0, 1, 0, 0, 16'h0999, 3'd0, "dec_ripple");
    press(0, 0, 0, 1, 16'h0000, 3'd0, "clr_only");
    press(0, 1, 0, 0, 16'h9999, 3'd0, "dec_top_borrow");
    press(1, 0, 0, 0, 16'h0000, 3'd0, "inc_top_carry");

    // cursor walk
    press(0, 0, 1, 0, 16'h0000, 3'd1, "nxt1");
    press(0, 0, 1, 0, 16'h0000, 3'd2, "nxt2");
    press(0, 0, 1, 0, 16'h0000, 3'd3, "nxt3");
    press(0, 0, 1, 0, 16'h0000, 3'd0, "nxt4");
    press(0, 0, 1, 0, 16'h0000, 3'd1, "nxt5");

    // combined events
    press(1, 0, 1, 0, 16'h0010, 3'd2, "inc_nxt");
    press(1, 1, 0, 0, 16'h0010, 3'd2, "inc_dec_cancel");
    press(0, 1, 0, 0, 16'h9910, 3'd2, "dec_mid_borrow");
    press(1, 0, 0, 1, 16'h0000, 3'd2, "clr_inc");
    press(0, 1, 1, 0, 16'h9900, 3'd3, "dec_nxt");

    repeat (3) tick();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d pending, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
